// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between fetch (IF) and load/store (DM) requesters.
// Define DMEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed DM-over-IF.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_mask,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic r_owner, r_last_gnt;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
  logic w_dm_win, w_grant, w_store, w_done;
  // owner and last_gnt encode 1 = DM, 0 = IF
`ifdef DMEM_ARB_RR_EN
  assign w_dm_win = dm_req & (~if_req | ~r_last_gnt);
`else
  assign w_dm_win = dm_req;
`endif
  assign w_grant = ~rst & (r_state == IDLE) & (if_req | dm_req);
  assign w_store = w_dm_win & dm_we;
  assign w_done  = ~rst & (r_state == WAIT) & (r_cnt <= 3'd1);
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = (w_grant & ~w_store) ? WAIT : IDLE;
    else                 w_next = (r_cnt <= 3'd1) ? IDLE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_grant) r_last_gnt <= w_dm_win;
      if (w_grant & ~w_store) begin
        r_owner <= w_dm_win;
        r_cnt   <= 3'(MEM_LAT);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_done & ~r_owner) r_if_rdata <= mem_rdata;
      if (w_done & r_owner)  r_dm_rdata <= mem_rdata;
    end
  end
  // rdata follows memory on the pulse cycle, otherwise holds the last returned word
  always_comb begin
    if_gnt    = w_grant & ~w_dm_win;
    dm_gnt    = w_grant & w_dm_win;
    mem_en    = w_grant;
    mem_we    = w_grant & w_store;
    mem_addr  = w_grant ? (w_dm_win ? dm_addr : if_addr) : '0;
    mem_wdata = (w_grant & w_dm_win) ? dm_wdata : '0;
    mem_mask  = w_grant ? (w_dm_win ? dm_mask : '1) : '0;
    if_rvalid = w_done & ~r_owner;
    dm_rvalid = w_done & r_owner;
    if_rdata  = rst ? '0 : (if_rvalid ? mem_rdata : r_if_rdata);
    dm_rdata  = rst ? '0 : (dm_rvalid ? mem_rdata : r_dm_rdata);
    busy      = ~rst & (r_state != IDLE);
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table plus read-return scoreboard for dmem_port_arbiter (MEM_LAT=2).
module tb_dmem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0] dm_mask = '0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_mask;
  always #5 clk = ~clk;
  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_mask(dm_mask),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .busy(busy));
  // memory model: reads appear LAT cycles after mem_en, filler otherwise
  logic [31:0] mem [256];
  logic [31:0] pipe [LAT];
  assign mem_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++) if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  typedef struct { logic dm; logic [31:0] data; int cyc; } sb_t;
  sb_t q[$];
  logic [31:0] last_if = '0, last_dm = '0;
  always @(negedge clk) begin
    if (if_rvalid || dm_rvalid) begin
      chk("both_rvalid", {31'd0, if_rvalid & dm_rvalid}, 32'd0);
      if (q.size() == 0) chk("unexpected_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
      else begin
        sb_t e;
        e = q.pop_front();
        chk("rvalid_owner", {31'd0, dm_rvalid}, {31'd0, e.dm});
        chk("rdata", dm_rvalid ? dm_rdata : if_rdata, e.data);
        chk("read_latency", 32'(cyc - e.cyc), 32'(LAT));
        if (e.dm) last_dm = e.data;
        else      last_if = e.data;
      end
    end
  end
  typedef struct { logic ir; logic [31:0] ia; logic dr; logic we; logic [31:0] da; logic [31:0] wd; logic [3:0] mk; logic [31:0] exp; } vec_t;
  vec_t vecs[11];
  function automatic vec_t fetch(input logic [31:0] a, input logic [31:0] e);
    return '{1'b1, a, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, e};
  endfunction
  function automatic vec_t dmv(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] mk, input logic [31:0] e);
    return '{1'b0, 32'd0, 1'b1, we, a, wd, mk, e};
  endfunction
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || q.size() != 0) && n < 20);
    chk("idle_timeout", {31'd0, n < 20}, 32'd1);
  endtask
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    if_req = v.ir; if_addr = v.ia; dm_req = v.dr; dm_we = v.we;
    dm_addr = v.da; dm_wdata = v.wd; dm_mask = v.mk;
    @(negedge clk);
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, v.ir});
    chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, v.dr});
    chk("mem_en", {31'd0, mem_en}, 32'd1);
    chk("mem_we", {31'd0, mem_we}, {31'd0, v.dr & v.we});
    chk("mem_addr", mem_addr, v.ir ? v.ia : v.da);
    chk("mem_mask", {28'd0, mem_mask}, {28'd0, v.ir ? 4'hF : v.mk});
    if (v.dr && v.we) chk("mem_wdata", mem_wdata, v.wd);
    chk("busy_issue", {31'd0, busy}, 32'd0);
    if (!(v.dr && v.we)) q.push_back('{v.dr, v.exp, cyc});
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    wait_idle();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    mem[4] <= 32'h0050_0093;
    vecs[0]  = fetch(32'h10, 32'h0050_0093);
    vecs[1]  = dmv(1'b1, 32'h104, 32'h0000_AB00, 4'b0010, 32'd0);
    vecs[2]  = dmv(1'b0, 32'h104, 32'd0, 4'hF, 32'hA000_AB41);
    vecs[3]  = dmv(1'b1, 32'h108, 32'h1122_3344, 4'hF, 32'd0);
    vecs[4]  = fetch(32'h108, 32'h1122_3344);
    vecs[5]  = dmv(1'b1, 32'h10C, 32'hCC00_0000, 4'b1000, 32'd0);
    vecs[6]  = dmv(1'b0, 32'h10C, 32'd0, 4'hF, 32'hCC00_0043);
    vecs[7]  = dmv(1'b0, 32'h200, 32'd0, 4'hF, 32'hA000_0080);
    vecs[8]  = fetch(32'h3FC, 32'hA000_00FF);
    vecs[9]  = dmv(1'b1, 32'h0, 32'h0000_00EE, 4'b0001, 32'd0);
    vecs[10] = fetch(32'h0, 32'hA000_00EE);
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    begin
      int g0, n;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      @(negedge clk);
      chk("dual_dm_first", {30'd0, if_gnt, dm_gnt}, 32'd1);
      q.push_back('{1'b1, 32'hA000_0080, cyc});
      g0 = cyc;
      @(posedge clk); #1;
      dm_req = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_gnt && n < 10);
      chk("dual_if_gap", 32'(cyc - g0), 32'(LAT + 1));
      q.push_back('{1'b0, 32'h0050_0093, cyc});
      @(posedge clk); #1;
      if_req = 1'b0;
      wait_idle();
      chk("if_rdata_hold", if_rdata, last_if);
      chk("dm_rdata_hold", dm_rdata, last_dm);
    end
    begin
      int k = 0, n = 0, gp = 0;
      logic exp_dm;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h108; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10C;
      while (k < 6 && n < 40) begin
        @(negedge clk); n++;
        if (if_gnt || dm_gnt) begin
`ifdef DMEM_ARB_RR_EN
          exp_dm = (k % 2 == 0);
`else
          exp_dm = 1'b1;
`endif
          chk("grant_order", {30'd0, if_gnt, dm_gnt}, exp_dm ? 32'd1 : 32'd2);
          if (k > 0) chk("grant_gap", 32'(cyc - gp), 32'(LAT + 1));
          q.push_back('{dm_gnt, dm_gnt ? 32'hCC00_0043 : 32'h1122_3344, cyc});
          gp = cyc;
          k++;
        end
      end
      chk("grant_count", 32'(k), 32'd6);
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;
      wait_idle();
    end
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    @(negedge clk);
    chk("mid_gnt", {31'd0, dm_gnt}, 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0; rst = 1'b1; q.delete();
    @(negedge clk);
    chk("mid_rst_out", {26'd0, if_gnt, dm_gnt, mem_en, busy, if_rvalid, dm_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out", {26'd0, if_gnt, dm_gnt, mem_en, busy, if_rvalid, dm_rvalid}, 32'd0);
    chk("post_rst_rdata", dm_rdata, 32'd0);
    repeat (3) @(negedge clk);
    run_vec(vecs[0]);
    wait_idle();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
